multi_channel_buffer: RTL and testbench
=======================================

MULTI_CHANNEL_BUFFER -- requirements
Module: multi_channel_buffer

Interface
REQ-001 Parameter NumChannels, default 4, number of independent FIFO channels sharing one storage array; SHALL be >= 2.
REQ-002 Parameter BufferDepth, default 8, entries per channel; SHALL be a power of two and >= 2.
REQ-003 Parameter DataWidth, default 64, bits per entry.
REQ-004 Derived widths: CW = $clog2(NumChannels), PW = $clog2(BufferDepth), NW = PW+1.
REQ-005 clk  in  1  sole clock; all state updates on posedge clk.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 wrValid  in  1  write request.
REQ-008 wrCh  in  CW  target channel of the write.
REQ-009 wrData  in  DataWidth  write payload.
REQ-010 wrReady  out  1  combinational; high when the channel selected by wrCh is neither full nor being flushed.
REQ-011 rdReq  in  1  read request.
REQ-012 rdCh  in  CW  source channel of the read.
REQ-013 rdValid  out  1  registered; high one cycle after an accepted read.
REQ-014 rdData  out  DataWidth  registered read payload.
REQ-015 rdChOut  out  CW  registered; channel that produced rdData.
REQ-016 flush  in  NumChannels  per-channel synchronous clear request.
REQ-017 full  out  NumChannels  per-channel; high when count == BufferDepth.
REQ-018 empty  out  NumChannels  per-channel; high when count == 0.
REQ-019 count  out  NumChannels*NW  per-channel occupancy; channel c occupies bits [c*NW +: NW].

Function
REQ-020 Each channel SHALL own a PW-bit write pointer, a PW-bit read pointer and an NW-bit count, all internal; storage address = {channel, pointer}.
REQ-021 A write SHALL be accepted iff wrValid && !full[wrCh] && !flush[wrCh]; on acceptance wrData is stored at that channel's write pointer, which then advances.
REQ-022 A read SHALL be accepted iff rdReq && !empty[rdCh] && !flush[rdCh]; on acceptance, on the next cycle rdValid=1, rdData=stored entry, rdChOut=rdCh, and the read pointer advances.
REQ-023 Read latency SHALL be exactly one cycle; a non-accepted read SHALL give rdValid=0 next cycle, and rdData/rdChOut SHALL hold their previous values.
REQ-024 Pointers SHALL wrap from BufferDepth-1 to 0.
REQ-025 full/empty/count SHALL reflect registered state only; no same-cycle bypass: a read of an empty channel is refused even if a write to it is accepted in the same cycle, and a write to a full channel is refused even if a read from it is accepted in the same cycle.
REQ-026 Same-cycle accepted write and read on the same channel SHALL leave that count unchanged; on different channels, each count SHALL change by +1 / -1.
REQ-027 flush[c]=1 SHALL set channel c's pointers and count to 0 on the next edge; other channels SHALL be unaffected; an accepted read issued the cycle before the flush SHALL still return its data.
REQ-028 Entries in channel c SHALL be returned in write order; channels SHALL never observe each other's data.
REQ-029 Any accepted write during a cycle with a concurrent accepted read to the same physical address SHALL be impossible by construction (pointer discipline); the bench SHALL assert this.

Reset
REQ-030 While rst=0: all pointers and counts = 0, empty = all ones, full = all zeros, rdValid=0, rdData=0, rdChOut=0; storage contents SHALL NOT be reset.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries and any read in flight (rdValid=0 immediately).

Verification
REQ-032 Fill ch1 with 0x11..0x18 (8 writes) -> full[1]=1, count[1]=8, wrReady=0 for wrCh=1; 9th write ignored; 8 reads return 0x11..0x18, rdChOut=1, then empty[1]=1.
REQ-033 Interleave writes ch0=0xA0, ch2=0xC0, ch0=0xA1; read ch2, ch0, ch0 -> 0xC0, 0xA0, 0xA1 each one cycle after request.
REQ-034 ch3 count=3, simultaneous accepted write+read on ch3 -> count stays 3; ch3 empty with simultaneous write+read -> read refused, rdValid=0, count=1.
REQ-035 ch0 holding 5 entries, ch1 holding 2, pulse flush[0] -> count[0]=0, empty[0]=1, count[1]=2 unchanged; write concurrent with flush to ch0 dropped.
REQ-036 Wrap: 6 writes/6 reads on ch2, then 8 writes 0x01..0x08 -> full, reads return 0x01..0x08 in order.
REQ-037 Assert rst low while rdValid=1 and count[0]=4 -> rdValid=0, count[0]=0, empty=all ones immediately.

Source files
------------

// File: rtl/multi_channel_buffer_if.sv
`default_nettype none
// =============================================================================
// multi_channel_buffer_if : write/read/flush/status bundle for multi_channel_buffer
// Rev 1.0
// =============================================================================
interface multi_channel_buffer_if #(
  parameter int NumChannels = 4,
  parameter int BufferDepth = 8,
  parameter int DataWidth   = 64
);
  localparam int CW = $clog2(NumChannels);
  localparam int PW = $clog2(BufferDepth);
  localparam int NW = PW + 1;

  logic                      wrValid;
  logic [CW-1:0]             wrCh;
  logic [DataWidth-1:0]      wrData;
  logic                      wrReady;
  logic                      rdReq;
  logic [CW-1:0]             rdCh;
  logic                      rdValid;
  logic [DataWidth-1:0]      rdData;
  logic [CW-1:0]             rdChOut;
  logic [NumChannels-1:0]    flush;
  logic [NumChannels-1:0]    full;
  logic [NumChannels-1:0]    empty;
  logic [NumChannels*NW-1:0] count;

  modport master (
    output wrValid, wrCh, wrData, rdReq, rdCh, flush,
    input  wrReady, rdValid, rdData, rdChOut, full, empty, count
  );

  modport slave (
    input  wrValid, wrCh, wrData, rdReq, rdCh, flush,
    output wrReady, rdValid, rdData, rdChOut, full, empty, count
  );
endinterface
`default_nettype wire

// File: rtl/multi_channel_buffer.sv
`default_nettype none
// =============================================================================
// multi_channel_buffer : N independent FIFO channels sharing one storage array
// Rev 1.0
// =============================================================================
module multi_channel_buffer #(
  parameter int NumChannels = 4,
  parameter int BufferDepth = 8,
  parameter int DataWidth   = 64
) (
  input  wire logic              clk,
  input  wire logic              rst,
  multi_channel_buffer_if.slave  bus
);
  localparam int CW = $clog2(NumChannels);
  localparam int PW = $clog2(BufferDepth);
  localparam int NW = PW + 1;
  localparam int AW = CW + PW;

  logic [DataWidth-1:0]   mem_q [NumChannels*BufferDepth];
  logic [PW-1:0]          wr_ptr_q [NumChannels];
  logic [PW-1:0]          wr_ptr_d [NumChannels];
  logic [PW-1:0]          rd_ptr_q [NumChannels];
  logic [PW-1:0]          rd_ptr_d [NumChannels];
  logic [NW-1:0]          cnt_q    [NumChannels];
  logic [NW-1:0]          cnt_d    [NumChannels];

  logic                   rd_valid_q, rd_valid_d;
  logic [DataWidth-1:0]   rd_data_q,  rd_data_d;
  logic [CW-1:0]          rd_ch_q,    rd_ch_d;

  logic [NumChannels-1:0] ch_full;
  logic [NumChannels-1:0] ch_empty;
  logic [NumChannels-1:0] wr_hit;
  logic [NumChannels-1:0] rd_hit;
  logic                   wr_ch_ok, rd_ch_ok;
  logic                   wr_ready, wr_acc, rd_acc;
  logic [AW-1:0]          wr_addr, rd_addr;

  generate
    for (genvar c = 0; c < NumChannels; c++) begin : g_status
      assign ch_full[c]               = (cnt_q[c] == NW'(BufferDepth));
      assign ch_empty[c]              = (cnt_q[c] == '0);
      assign bus.count[c*NW +: NW]    = cnt_q[c];
    end
  endgenerate

  assign bus.full  = ch_full;
  assign bus.empty = ch_empty;

  // Status comes from registered counts only, so same-cycle traffic never bypasses full/empty
  assign wr_ch_ok = (32'(bus.wrCh) < 32'(NumChannels));
  assign rd_ch_ok = (32'(bus.rdCh) < 32'(NumChannels));
  assign wr_ready = wr_ch_ok && !ch_full[bus.wrCh] && !bus.flush[bus.wrCh];
  assign wr_acc   = bus.wrValid && wr_ready;
  assign rd_acc   = bus.rdReq && rd_ch_ok && !ch_empty[bus.rdCh] && !bus.flush[bus.rdCh];

  assign bus.wrReady = wr_ready;
  assign wr_addr     = {bus.wrCh, wr_ptr_q[bus.wrCh]};
  assign rd_addr     = {bus.rdCh, rd_ptr_q[bus.rdCh]};

  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    for (int c = 0; c < NumChannels; c++) begin
      wr_hit[c] = wr_acc && (bus.wrCh == CW'(c));
      rd_hit[c] = rd_acc && (bus.rdCh == CW'(c));
    end
  end

  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      cnt_d[c]    = cnt_q[c];
      if (bus.flush[c]) begin
        wr_ptr_d[c] = '0;
        rd_ptr_d[c] = '0;
        cnt_d[c]    = '0;
      end else begin
        if (wr_hit[c]) wr_ptr_d[c] = wr_ptr_q[c] + PW'(1);
        if (rd_hit[c]) rd_ptr_d[c] = rd_ptr_q[c] + PW'(1);
        cnt_d[c] = cnt_q[c] + NW'(wr_hit[c]) - NW'(rd_hit[c]);
      end
    end
  end

  always_comb begin
    rd_valid_d = rd_acc;
    rd_data_d  = rd_data_q;
    rd_ch_d    = rd_ch_q;
    if (rd_acc) begin
      rd_data_d = mem_q[rd_addr];
      rd_ch_d   = bus.rdCh;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NumChannels; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ch_q    <= '0;
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_ch_q    <= rd_ch_d;
    end
  end

  // Payload storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_addr] <= bus.wrData;
  end

  assign bus.rdValid = rd_valid_q;
  assign bus.rdData  = rd_data_q;
  assign bus.rdChOut = rd_ch_q;
endmodule
`default_nettype wire

// File: tb/tb_multi_channel_buffer.sv
`default_nettype none
// =============================================================================
// tb_multi_channel_buffer : scoreboard bench for multi_channel_buffer
// Rev 1.0
// =============================================================================
module tb_multi_channel_buffer;
  localparam int NC = 4;
  localparam int D  = 8;
  localparam int DW = 64;
  localparam int NW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_channel_buffer_if #(.NumChannels(NC), .BufferDepth(D), .DataWidth(DW)) bus();

  multi_channel_buffer #(.NumChannels(NC), .BufferDepth(D), .DataWidth(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] data;
  } rd_item_t;

  rd_item_t      exp_q [$];
  logic [DW-1:0] model_q [NC][$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] last_data = '0;
  logic [1:0]    last_ch   = '0;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic check_status();
    for (int c = 0; c < NC; c++) begin
      check($sformatf("count[%0d]", c), 64'(bus.count[c*NW +: NW]), 64'(model_q[c].size()));
      check($sformatf("full[%0d]", c),  64'(bus.full[c]),  64'(model_q[c].size() == D));
      check($sformatf("empty[%0d]", c), 64'(bus.empty[c]), 64'(model_q[c].size() == 0));
    end
  endtask

  // Called just after a rising edge; drives one cycle of stimulus and checks its result
  task automatic step(input logic wv, input int wch, input logic [DW-1:0] wd,
                      input logic rr, input int rch, input logic [NC-1:0] fl);
    logic     wacc, racc, exp_valid;
    rd_item_t it;
    bus.wrValid = wv;
    bus.wrCh    = 2'(wch);
    bus.wrData  = wd;
    bus.rdReq   = rr;
    bus.rdCh    = 2'(rch);
    bus.flush   = fl;
    #1;
    wacc = wv && (model_q[wch].size() < D) && !fl[wch];
    racc = rr && (model_q[rch].size() > 0) && !fl[rch];
    check("wrReady", 64'(bus.wrReady), 64'((model_q[wch].size() < D) && !fl[wch]));
    if (wacc && racc && (wch == rch))
      check("addr_collision", 64'(dut.wr_ptr_q[wch] != dut.rd_ptr_q[rch]), 64'd1);
    @(posedge clk);
    exp_valid = racc;
    if (racc) begin
      it.ch   = 2'(rch);
      it.data = model_q[rch].pop_front();
      exp_q.push_back(it);
    end
    if (wacc) model_q[wch].push_back(wd);
    for (int c = 0; c < NC; c++)
      if (fl[c]) model_q[c].delete();
    #1;
    check("rdValid", 64'(bus.rdValid), 64'(exp_valid));
    if (bus.rdValid) begin
      check("sb_depth", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        check("rdData",  bus.rdData,         it.data);
        check("rdChOut", 64'(bus.rdChOut),   64'(it.ch));
        last_data = it.data;
        last_ch   = it.ch;
      end
    end else begin
      exp_q.delete();
      check("rdData_hold",  bus.rdData,       last_data);
      check("rdChOut_hold", 64'(bus.rdChOut), 64'(last_ch));
    end
    check_status();
  endtask

  task automatic wr(input int ch, input logic [DW-1:0] d);
    step(1'b1, ch, d, 1'b0, 0, '0);
  endtask

  task automatic rd(input int ch);
    step(1'b0, 0, '0, 1'b1, ch, '0);
  endtask

  task automatic check_reset_outputs();
    check("rst_rdValid", 64'(bus.rdValid), 64'd0);
    check("rst_rdData",  bus.rdData,       64'd0);
    check("rst_rdChOut", 64'(bus.rdChOut), 64'd0);
    check("rst_empty",   64'(bus.empty),   64'hF);
    check("rst_full",    64'(bus.full),    64'h0);
    check("rst_count",   64'(bus.count),   64'h0);
  endtask

  initial begin
    bus.wrValid = 1'b0;
    bus.wrCh    = '0;
    bus.wrData  = '0;
    bus.rdReq   = 1'b0;
    bus.rdCh    = '0;
    bus.flush   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Fill channel 1, overflow attempt, drain in order
    for (int i = 0; i < 8; i++) wr(1, 64'(8'h11 + i));
    check("ch1_full", 64'(bus.full[1]), 64'd1);
    wr(1, 64'h99);
    for (int i = 0; i < 8; i++) rd(1);
    check("ch1_empty", 64'(bus.empty[1]), 64'd1);

    // Interleaved channels
    wr(0, 64'hA0);
    wr(2, 64'hC0);
    wr(0, 64'hA1);
    rd(2);
    rd(0);
    rd(0);

    // Simultaneous write+read on ch3, then on an empty ch3
    for (int i = 0; i < 3; i++) wr(3, 64'h30 + 64'(i));
    step(1'b1, 3, 64'h33, 1'b1, 3, '0);
    for (int i = 0; i < 3; i++) rd(3);
    step(1'b1, 3, 64'h3F, 1'b1, 3, '0);
    rd(3);

    // Flush ch0 while ch1 holds data; read issued the cycle before still returns
    for (int i = 0; i < 5; i++) wr(0, 64'hB0 + 64'(i));
    wr(1, 64'hD0);
    wr(1, 64'hD1);
    rd(0);
    step(1'b1, 0, 64'hEE, 1'b0, 0, 4'b0001);
    rd(1);
    rd(1);

    // Pointer wrap on ch2
    for (int i = 0; i < 6; i++) wr(2, 64'h200 + 64'(i));
    for (int i = 0; i < 6; i++) rd(2);
    for (int i = 0; i < 8; i++) wr(2, 64'(i + 1));
    check("ch2_full", 64'(bus.full[2]), 64'd1);
    for (int i = 0; i < 8; i++) rd(2);

    // Random mixed traffic
    for (int n = 0; n < 300; n++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, NC-1)), {$urandom, $urandom},
           1'($urandom_range(0, 1)), int'($urandom_range(0, NC-1)),
           ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, NC-1)) : 4'b0000);
    end

    // Asynchronous reset with a read in flight and ch0 holding 4
    step(1'b0, 0, '0, 1'b0, 0, 4'b1111);
    for (int i = 0; i < 5; i++) wr(0, 64'hF0 + 64'(i));
    rd(0);
    check("pre_rst_rdValid", 64'(bus.rdValid), 64'd1);
    check("pre_rst_count0",  64'(bus.count[0 +: NW]), 64'd4);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    for (int c = 0; c < NC; c++) model_q[c].delete();
    exp_q.delete();
    last_data = '0;
    last_ch   = '0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    wr(0, 64'h5A);
    rd(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
